// File: rtl/team_06_lcd_sequencer_pkg.sv
// Shared types and constants for the LCD frame sequencer.
//   seq_state_t  : sequencer FSM states
//   EFFECT_CODE  : LCD character code shown for each of the four effects
//   BL/EN/RW/RS  : PCF8574 backpack control bit positions in the low nibble
//   CTRL_EN_HI/LO: low-nibble control patterns with EN raised / dropped
package team_06_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_DONE,
    GAP,
    ERROR
  } seq_state_t;

  localparam logic [7:0] EFFECT_CODE [4] = '{8'h20, 8'h2A, 8'h23, 8'h40};

  localparam int BL = 3;
  localparam int EN = 2;
  localparam int RW = 1;
  localparam int RS = 0;

  // Backlight on, data register, write; EN pulsed high then low so the
  // HD44780 latches the nibble on the falling edge.
  localparam logic [3:0] CTRL_EN_HI = (4'b1 << BL) | (4'b1 << EN) | (4'b1 << RS);
  localparam logic [3:0] CTRL_EN_LO = (4'b1 << BL) | (4'b1 << RS);

  localparam logic [2:0] LAST_BYTE = 3'd4;

endpackage

// File: rtl/team_06_lcd_sequencer_if.sv
// Byte-level handshake between the frame sequencer and the I2C byte master.
//   master modport: sequencer side (drives byte requests)
//   slave  modport: I2C byte master side (ready / done / nack)
interface team_06_lcd_sequencer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_stop;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_nack;

  modport master (
    output tx_valid, tx_data, tx_start, tx_stop,
    input  tx_ready, tx_done, tx_nack
  );

  modport slave (
    input  tx_valid, tx_data, tx_start, tx_stop,
    output tx_ready, tx_done, tx_nack
  );
endinterface

// File: rtl/team_06_lcd_sequencer_frame_rom.sv
// Combinational frame byte table.
//   byte_idx : position in the 5-byte frame (0..4)
//   code     : character code frozen for this frame
//   tx_data  : byte for that position
//   tx_start : START before this byte (address byte only)
//   tx_stop  : STOP after this byte (last byte only)
module team_06_lcd_frame_rom
  import team_06_lcd_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h27
) (
  input  logic [2:0] byte_idx,
  input  logic [7:0] code,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       tx_stop
);

  always_comb begin
    tx_data  = '0;
    tx_start = 1'b0;
    tx_stop  = 1'b0;
    case (byte_idx)
      3'd0: begin
        tx_data  = {SLAVE_ADDR, 1'b0};
        tx_start = 1'b1;
      end
      3'd1: tx_data = {code[7:4], CTRL_EN_HI};
      3'd2: tx_data = {code[7:4], CTRL_EN_LO};
      3'd3: tx_data = {code[3:0], CTRL_EN_HI};
      3'd4: begin
        tx_data = {code[3:0], CTRL_EN_LO};
        tx_stop = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/team_06_lcd_sequencer.sv
// Frame-level LCD sequencer: turns effect changes into 5-byte PCF8574 frames
// for a byte-level I2C master, with coalescing, NACK retry and sticky error.
//   clk, rst_n : clock, async active-low reset
//   effect     : selected effect; any change requests a frame
//   bus        : byte handshake to the I2C master (master modport)
//   busy       : frame in progress (not IDLE / ERROR)
//   err        : sticky retry-exhausted flag, cleared by the next effect change
module team_06_lcd_sequencer
  import team_06_lcd_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter int         GAP_CYCLES = 1000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   effect,
  team_06_lcd_sequencer_if.master      bus,
  output logic                         busy,
  output logic                         err
);

  localparam int RW_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW   = $clog2(GAP_CYCLES + 1);

  seq_state_t      state_q, state_d;
  logic [1:0]      effect_q;
  logic            pending_q;
  logic [7:0]      code_q;
  logic [7:0]      frame_q, frame_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [RW_W-1:0] retry_q, retry_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            err_q, err_d;
  logic            take_pending;

  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            tx_stop_q, tx_stop_d;

  logic [7:0]      rom_data;
  logic            rom_start, rom_stop;

  team_06_lcd_frame_rom #(.SLAVE_ADDR(SLAVE_ADDR)) u_rom (
    .byte_idx (byte_idx_q),
    .code     (frame_q),
    .tx_data  (rom_data),
    .tx_start (rom_start),
    .tx_stop  (rom_stop)
  );

  // Change detect. A change on the same edge the FSM consumes pending wins,
  // so the newer code still gets its own frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      effect_q  <= 2'd0;
      pending_q <= 1'b0;
      code_q    <= 8'h00;
    end else begin
      effect_q <= effect;
      if (effect != effect_q) begin
        pending_q <= 1'b1;
        code_q    <= EFFECT_CODE[effect];
      end else if (take_pending) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= 8'h00;
      byte_idx_q <= 3'd0;
      retry_q    <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      tx_stop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_stop_q  <= tx_stop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    byte_idx_d   = byte_idx_q;
    retry_d      = retry_q;
    gap_d        = gap_q;
    err_d        = err_q;
    take_pending = 1'b0;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = tx_start_q;
    tx_stop_d    = tx_stop_q;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          take_pending = 1'b1;
          frame_d      = code_q;
          byte_idx_d   = 3'd0;
          state_d      = LOAD;
        end
      end

      LOAD: begin
        tx_valid_d = 1'b1;
        tx_data_d  = rom_data;
        tx_start_d = rom_start;
        tx_stop_d  = rom_stop;
        state_d    = ISSUE;
      end

      ISSUE: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          tx_start_d = 1'b0;
          tx_stop_d  = 1'b0;
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (!bus.tx_nack) begin
            if (byte_idx_q < LAST_BYTE) begin
              byte_idx_d = byte_idx_q + 3'd1;
              state_d    = LOAD;
            end else begin
              retry_d = '0;
              gap_d   = '0;
              state_d = GAP;
            end
          end else if (retry_q < RW_W'(MAX_RETRY)) begin
            // The master already sent STOP on the NACK; restart from the address.
            retry_d    = retry_q + RW_W'(1);
            byte_idx_d = 3'd0;
            gap_d      = '0;
            state_d    = GAP;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end

      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          // Non-zero retry count means this gap precedes a re-attempt.
          state_d = (retry_q != '0) ? LOAD : IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      ERROR: begin
        if (pending_q) begin
          take_pending = 1'b1;
          err_d        = 1'b0;
          retry_d      = '0;
          frame_d      = code_q;
          byte_idx_d   = 3'd0;
          state_d      = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_stop  = tx_stop_q;
  assign busy         = (state_q != IDLE) && (state_q != ERROR);
  assign err          = err_q;

endmodule

// File: tb/tb_team_06_lcd_sequencer.sv
module tb_team_06_lcd_sequencer;

  localparam int GAP  = 16;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] effect = 2'd0;
  logic       busy, err;

  team_06_lcd_sequencer_if bus();

  team_06_lcd_sequencer #(
    .SLAVE_ADDR (7'h27),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .effect (effect),
    .bus    (bus.master),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       start;
    logic       stop;
  } exp_t;

  exp_t exp_q[$];
  int   start_cyc[$];
  int   total = 0;
  int   bad   = 0;

  // responder knobs
  int         mode_rand  = 0;
  int         nack_left  = 0;
  int         stall_left = 0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int code_of(input int e);
    case (e)
      0: return 'h20;
      1: return 'h2A;
      2: return 'h23;
      default: return 'h40;
    endcase
  endfunction

  // Reference frame: address+W, then high and low nibble each with EN high then low.
  task automatic push_frame(input int code, input int n);
    logic [7:0] b [5];
    int hi, lo;
    hi = code / 16;
    lo = code % 16;
    b[0] = 8'('h27 * 2);
    b[1] = 8'(hi * 16 + 13);
    b[2] = 8'(hi * 16 + 9);
    b[3] = 8'(lo * 16 + 13);
    b[4] = 8'(lo * 16 + 9);
    for (int i = 0; i < n; i++)
      exp_q.push_back({b[i], (i == 0), (i == 4)});
  endtask

  task automatic push_addr(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'h4E, 1'b1, 1'b0});
  endtask

  task automatic set_effect(input int e);
    @(negedge clk);
    effect = 2'(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 4000 && !(exp_q.size() == 0 && busy == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && busy == 1'b0)}, 32'd1);
  endtask

  // I2C byte master model: ready, done after a latency, NACK on address bytes.
  initial begin
    int   done_cnt;
    logic done_nack;
    done_cnt = 0;
    done_nack = 1'b0;
    bus.tx_ready = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_nack  = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      bus.tx_nack = 1'b0;
      if (!rst_n) begin
        done_cnt = 0;
        bus.tx_ready = 1'b0;
        continue;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          bus.tx_done = 1'b1;
          bus.tx_nack = done_nack;
        end
      end
      if (stall_left > 0 && bus.tx_valid && bus.tx_data == stall_data) begin
        bus.tx_ready = 1'b0;
        stall_left--;
      end else if (mode_rand != 0) begin
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.tx_ready = 1'b1;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        done_cnt  = (mode_rand != 0) ? int'($urandom_range(1, 4)) : 1;
        done_nack = bus.tx_start && (nack_left > 0);
        if (done_nack) nack_left--;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    exp_t       e;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (pv && !pr)
          check("hold_payload", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, pd});
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte actual=%0h required=none", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", {24'd0, bus.tx_data}, {24'd0, e.data});
            check("byte_ctl", {30'd0, bus.tx_start, bus.tx_stop}, {30'd0, e.start, e.stop});
            check("busy_in_frame", {31'd0, busy}, 32'd1);
          end
          if (bus.tx_start) start_cyc.push_back(cyc);
        end
      end
      pv = bus.tx_valid && rst_n;
      pr = bus.tx_ready;
      pd = bus.tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, found, seen, cur, e, k;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {19'd0, bus.tx_valid, bus.tx_data, bus.tx_start, bus.tx_stop, busy, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic frame 0->1
    push_frame(code_of(1), 5);
    set_effect(1);
    repeat (3) @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1_drain");

    // 2: 20-cycle ready stall on byte 2 (0x29)
    stall_data = 8'h29;
    stall_left = 20;
    push_frame(code_of(2), 5);
    set_effect(2);
    wait_idle("t2_drain");
    check("t2_stall_used", stall_left, 0);

    // 3: changes during byte 1 coalesce into one following frame
    push_frame(code_of(1), 5);
    set_effect(1);
    found = 0;
    for (n = 0; n < 200 && found == 0; n++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_data == 8'h2D) found = 1;
    end
    check("t3_byte1_seen", found, 1);
    set_effect(2);
    set_effect(3);
    push_frame(code_of(3), 5);
    wait_idle("t3_drain");

    // 4: two NACKed address attempts, then success
    start_cyc.delete();
    nack_left = 2;
    push_addr(2);
    push_frame(code_of(0), 5);
    set_effect(0);
    wait_idle("t4_drain");
    check("t4_attempts", start_cyc.size(), 3);
    if (start_cyc.size() >= 3) begin
      check("t4_gap1", start_cyc[1] - start_cyc[0], GAP + 3);
      check("t4_gap2", start_cyc[2] - start_cyc[1], GAP + 3);
    end
    check("t4_err", {31'd0, err}, 32'd0);

    // 5: retries exhausted -> ERROR, then recovery on effect change
    nack_left = 4;
    push_addr(4);
    set_effect(3);
    n = 0;
    while (n < 4000 && err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("t5_err_set", {31'd0, err}, 32'd1);
    seen = 0;
    repeat (3 * GAP) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1;
    end
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_silent", seen, 0);
    check("t5_all_attempts", exp_q.size(), 0);
    push_frame(code_of(1), 5);
    set_effect(1);
    repeat (3) @(negedge clk);
    check("t5_err_clr", {31'd0, err}, 32'd0);
    wait_idle("t5_drain");

    // 6: async reset while byte 3 is held
    stall_data = 8'h3D;
    stall_left = 1000;
    push_frame(code_of(2), 3);
    set_effect(2);
    found = 0;
    for (n = 0; n < 200 && found == 0; n++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_data == 8'h3D) found = 1;
    end
    check("t6_byte3_seen", found, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_clr", {19'd0, bus.tx_valid, bus.tx_data, bus.tx_start, bus.tx_stop, busy, err}, 32'd0);
    effect = 2'd0;
    stall_left = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1;
    end
    check("t6_quiet", seen, 0);
    check("t6_consumed", exp_q.size(), 0);
    push_frame(code_of(1), 5);
    set_effect(1);
    wait_idle("t6_drain");

    // random: effect sequence, ready stalls, done latency, address NACKs
    mode_rand = 1;
    cur = 1;
    repeat (10) begin
      e = int'($urandom_range(0, 3));
      while (e == cur) e = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 2));
      nack_left = k;
      push_addr(k);
      push_frame(code_of(e), 5);
      set_effect(e);
      wait_idle("rnd_drain");
      check("rnd_err", {31'd0, err}, 32'd0);
      cur = e;
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
